// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the HI/LO multiply/divide engine: MulOpE opcodes and
// sequencer states.
package muldiv_unit_pkg;

    localparam logic [1:0] MULOP_MULT  = 2'b00;
    localparam logic [1:0] MULOP_MULTU = 2'b01;
    localparam logic [1:0] MULOP_DIV   = 2'b10;
    localparam logic [1:0] MULOP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } md_state_t;

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// Radix-2 restoring divider on unsigned magnitudes: one quotient bit per cycle,
// WIDTH cycles per divide, done asserted during the final step.
module div_iter
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic             done,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

    logic             active_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] div_r;

    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH:0]   diff_s;
    logic             ge_s;

    // Partial remainder gains one bit, so compare at WIDTH+1 to keep the carry.
    assign rem_sh_s = {rem_r, quo_r[WIDTH-1]};
    assign diff_s   = rem_sh_s - {1'b0, div_r};
    assign ge_s     = ~diff_s[WIDTH];

    assign done = active_r & (cnt_r == {CW{1'b0}});
    assign quo  = quo_r;
    assign rem  = rem_r;

    // Load on start, then one shift/subtract step per cycle while active.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_r <= 1'b0;
            cnt_r    <= {CW{1'b0}};
            rem_r    <= {WIDTH{1'b0}};
            quo_r    <= {WIDTH{1'b0}};
            div_r    <= {WIDTH{1'b0}};
        end else if (start) begin
            active_r <= 1'b1;
            cnt_r    <= CNT_INIT;
            rem_r    <= {WIDTH{1'b0}};
            quo_r    <= a_mag;
            div_r    <= b_mag;
        end else if (active_r) begin
            rem_r <= ge_s ? diff_s[WIDTH-1:0] : rem_sh_s[WIDTH-1:0];
            quo_r <= {quo_r[WIDTH-2:0], ge_s};
            if (cnt_r == {CW{1'b0}}) begin
                active_r <= 1'b0;
            end else begin
                cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
            end
        end else begin
            active_r <= 1'b0;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// EX-stage multiply/divide engine owning HI/LO: fixed-latency MULT/MULTU,
// iterative DIV/DIVU with sign fixup, and MTHI/MTLO writes.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int WIDTH      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StartE,
    input  logic [1:0]       MulOpE,
    input  logic             MTHILOE,
    input  logic             HiLoSelE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    output logic             Mul_BusyE,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_CYCLES - 1);

    md_state_t          state_r;
    logic [3:0]         cnt_r;
    logic [2*WIDTH-1:0] prod_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic [WIDTH-1:0]   orig_a_r;
    logic               neg_q_r;
    logic               neg_r_r;
    logic               dz_r;

    logic               is_signed_s;
    logic               is_div_s;
    logic               a_neg_s;
    logic               b_neg_s;
    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;
    logic [2*WIDTH-1:0] a_ext_s;
    logic [2*WIDTH-1:0] b_ext_s;
    logic [2*WIDTH-1:0] prod_s;
    logic               div_start_s;
    logic               div_done_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]   q_fix_s;
    logic [WIDTH-1:0]   r_fix_s;

    assign is_signed_s = (MulOpE == MULOP_MULT) || (MulOpE == MULOP_DIV);
    assign is_div_s    = (MulOpE == MULOP_DIV)  || (MulOpE == MULOP_DIVU);
    assign a_neg_s     = is_signed_s & SrcAE[WIDTH-1];
    assign b_neg_s     = is_signed_s & SrcBE[WIDTH-1];
    assign a_mag_s     = a_neg_s ? -SrcAE : SrcAE;
    assign b_mag_s     = b_neg_s ? -SrcBE : SrcBE;

    // Sign-extended operands multiplied modulo 2^(2*WIDTH) give the signed product.
    assign a_ext_s = a_neg_s ? {{WIDTH{1'b1}}, SrcAE} : {{WIDTH{1'b0}}, SrcAE};
    assign b_ext_s = b_neg_s ? {{WIDTH{1'b1}}, SrcBE} : {{WIDTH{1'b0}}, SrcBE};
    assign prod_s  = a_ext_s * b_ext_s;

    assign div_start_s = (state_r == IDLE) & StartE & is_div_s;
    assign q_fix_s     = neg_q_r ? -quo_s : quo_s;
    assign r_fix_s     = neg_r_r ? -rem_s : rem_s;

    // Busy follows StartE combinationally so the next instruction stalls at issue.
    assign Mul_BusyE = ~reset & (StartE | (state_r != IDLE));
    assign HI        = hi_r;
    assign LO        = lo_r;

    div_iter #(.WIDTH(WIDTH)) u_div_iter (
        .clk   (clk),
        .reset (reset),
        .start (div_start_s),
        .a_mag (a_mag_s),
        .b_mag (b_mag_s),
        .done  (div_done_s),
        .quo   (quo_s),
        .rem   (rem_s)
    );

    // Sequencer and HI/LO registers; HI/LO change only on their single write edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            cnt_r    <= 4'd0;
            prod_r   <= {(2*WIDTH){1'b0}};
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
            orig_a_r <= {WIDTH{1'b0}};
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            dz_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (StartE && !is_div_s) begin
                        prod_r <= prod_s;
                        if (MUL_CYCLES == 1) begin
                            hi_r <= prod_s[2*WIDTH-1:WIDTH];
                            lo_r <= prod_s[WIDTH-1:0];
                        end else begin
                            cnt_r   <= MUL_CNT_INIT;
                            state_r <= MUL;
                        end
                    end else if (StartE) begin
                        neg_q_r  <= a_neg_s ^ b_neg_s;
                        neg_r_r  <= a_neg_s;
                        dz_r     <= (SrcBE == {WIDTH{1'b0}});
                        orig_a_r <= SrcAE;
                        state_r  <= DIV;
                    end else if (MTHILOE && HiLoSelE) begin
                        hi_r <= SrcAE;
                    end else if (MTHILOE) begin
                        lo_r <= SrcAE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                MUL: begin
                    cnt_r <= cnt_r - 4'd1;
                    if (cnt_r == 4'd1) begin
                        hi_r    <= prod_r[2*WIDTH-1:WIDTH];
                        lo_r    <= prod_r[WIDTH-1:0];
                        state_r <= IDLE;
                    end else begin
                        state_r <= MUL;
                    end
                end
                DIV: begin
                    if (div_done_s) begin
                        state_r <= FIX;
                    end else begin
                        state_r <= DIV;
                    end
                end
                FIX: begin
                    hi_r    <= dz_r ? orig_a_r : r_fix_s;
                    lo_r    <= dz_r ? {WIDTH{1'b1}} : q_fix_s;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
